axi_sram_slave: RTL and testbench

//   AXI3 responder (slave) fronting an on-chip word-wide SRAM. Terminates the AXI

---
 rtl/axi_sram_slave.sv | 192 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 slave in front of a 32-bit synchronous SRAM. It handles one transaction at a time
// with bursts of up to 16 beats, and reads and writes alternate priority when both arrive together.
module axi_sram_slave #(
    parameter int ADDR_W = 12,
    parameter int ID_W   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [3:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [3:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    state_t            state_r;
    logic              prio_wr_r;
    logic [31:0]       addr_r;
    logic [3:0]        len_r;
    logic [3:0]        cnt_r;
    logic [2:0]        size_r;
    logic [1:0]        burst_r;
    logic              err_r;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic              w_take_s;
    logic              beat_last_s;
    logic              wlast_bad_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic              unused_s;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] br);
        if (br == BURST_FIXED) begin
            return a;
        end else begin
            return a + (32'd1 << sz);
        end
    endfunction

    // When both channels are valid, the prio flag makes exactly one ready go high.
    assign arready     = (state_r == IDLE) & arvalid & (~awvalid | ~prio_wr_r);
    assign awready     = (state_r == IDLE) & awvalid & (~arvalid |  prio_wr_r);
    assign w_take_s    = wready & wvalid;
    assign beat_last_s = (cnt_r == len_r);
    assign wlast_bad_s = (wlast != beat_last_s);
    assign word_idx_s  = addr_r[ADDR_W+1:2];
    assign rresp       = RESP_OKAY;
    assign unused_s    = ^wid;

    // Byte-lane RAM write on each accepted W beat (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_take_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx_s][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered channel outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            prio_wr_r <= 1'b0;
            addr_r    <= 32'd0;
            len_r     <= 4'd0;
            cnt_r     <= 4'd0;
            size_r    <= 3'd0;
            burst_r   <= 2'd0;
            err_r     <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= RESP_OKAY;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rid       <= '0;
            rdata     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (arready) begin
                        rid       <= arid;
                        addr_r    <= araddr;
                        len_r     <= arlen;
                        size_r    <= arsize;
                        burst_r   <= arburst;
                        cnt_r     <= 4'd0;
                        err_r     <= 1'b0;
                        prio_wr_r <= 1'b1;
                        state_r   <= RD_REQ;
                    end else if (awready) begin
                        bid       <= awid;
                        addr_r    <= awaddr;
                        len_r     <= awlen;
                        size_r    <= awsize;
                        burst_r   <= awburst;
                        cnt_r     <= 4'd0;
                        err_r     <= 1'b0;
                        prio_wr_r <= 1'b0;
                        wready    <= 1'b1;
                        state_r   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_take_s) begin
                        addr_r <= next_addr(addr_r, size_r, burst_r);
                        cnt_r  <= cnt_r + 4'd1;
                        if (wlast_bad_s) begin
                            err_r <= 1'b1;
                        end
                        // Beat count, not wlast, ends the burst.
                        if (beat_last_s) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (err_r | wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
                            state_r <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RD_REQ: begin
                    rdata   <= mem[word_idx_s];
                    rlast   <= beat_last_s;
                    rvalid  <= 1'b1;
                    state_r <= RD_DATA;
                end
                RD_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (beat_last_s) begin
                            state_r <= IDLE;
                        end else begin
                            addr_r  <= next_addr(addr_r, size_r, burst_r);
                            cnt_r   <= cnt_r + 4'd1;
                            state_r <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave. It covers single, byte-strobe, burst, FIXED and
// narrow accesses, read/write arbitration, the wlast error and reset in the middle of a burst.
module tb_axi_sram_slave;

    logic        clk;
    logic        resetn;
    logic [3:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] ed [16];
    int          n_checks;
    int          n_fail;

    axi_sram_slave #(.ADDR_W(12), .ID_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                           input logic [1:0] br, input logic [3:0] id);
        int t;
        awaddr = a; awlen = len; awsize = sz; awburst = br; awid = id; awvalid = 1'b1;
        #1;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk); #1; t++; end
        check("aw_accept", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] len, input int wlast_beat);
        int t;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_beat); wvalid = 1'b1;
            #1;
            t = 0;
            while (!wready && t < 20) begin @(negedge clk); #1; t++; end
            check("w_ready", 32'(wready), 32'd1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_ready_drop", 32'(wready), 32'd0);
    endtask

    task automatic get_b(input logic [1:0] exp_resp, input logic [3:0] id);
        int t;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 20) begin @(negedge clk); t++; end
        check("b_valid", 32'(bvalid), 32'd1);
        check("b_resp", 32'(bresp), 32'(exp_resp));
        check("b_id", 32'(bid), 32'(id));
        @(negedge clk);
        bready = 1'b0;
        check("b_done", 32'(bvalid), 32'd0);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                           input logic [1:0] br, input logic [3:0] id);
        int t;
        araddr = a; arlen = len; arsize = sz; arburst = br; arid = id; arvalid = 1'b1;
        #1;
        t = 0;
        while (!arready && t < 20) begin @(negedge clk); #1; t++; end
        check("ar_accept", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Entered on the negedge right after the AR handshake.
    task automatic get_r(input logic [3:0] len, input logic [3:0] id, input bit stall);
        int t;
        check("r_lat_t1", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("r_lat_t2", 32'(rvalid), 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!rvalid && t < 20) begin @(negedge clk); t++; end
            check("r_valid", 32'(rvalid), 32'd1);
            check("r_data", rdata, ed[b]);
            check("r_last", 32'(rlast), 32'(b == int'(len)));
            check("r_id", 32'(rid), 32'(id));
            check("r_resp", 32'(rresp), 32'd0);
            if (stall) begin
                @(negedge clk);
                check("r_hold_valid", 32'(rvalid), 32'd1);
                check("r_hold_data", rdata, ed[b]);
                check("r_hold_last", 32'(rlast), 32'(b == int'(len)));
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check("r_idle", 32'(rvalid), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int t;
        n_checks = 0; n_fail = 0;
        awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
        wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
        rready = 1'b0;
        do_reset();

        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bid_bresp", {26'd0, bid, bresp}, 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        send_aw(32'h10, 4'd0, 3'd2, 2'd1, 4'h3);
        send_w(4'd0, 0);
        get_b(2'b00, 4'h3);
        ed[0] = 32'hDEADBEEF;
        send_ar(32'h10, 4'd0, 3'd2, 2'd1, 4'h5);
        get_r(4'd0, 4'h5, 1'b0);

        // byte-lane write
        wd[0] = 32'h0000AA00; ws[0] = 4'b0010;
        send_aw(32'h10, 4'd0, 3'd2, 2'd1, 4'h4);
        send_w(4'd0, 0);
        get_b(2'b00, 4'h4);
        ed[0] = 32'hDEADAAEF;
        send_ar(32'h10, 4'd0, 3'd2, 2'd1, 4'h6);
        get_r(4'd0, 4'h6, 1'b0);

        // INCR burst of 4, read back with stalls
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1); ws[i] = 4'hF; ed[i] = 32'(i + 1);
        end
        send_aw(32'h100, 4'd3, 3'd2, 2'd1, 4'hB);
        send_w(4'd3, 3);
        get_b(2'b00, 4'hB);
        send_ar(32'h100, 4'd3, 3'd2, 2'd1, 4'hC);
        get_r(4'd3, 4'hC, 1'b1);

        // narrow INCR reads step by one byte: 0x103,0x104,0x105,0x106
        ed[0] = 32'd1; ed[1] = 32'd2; ed[2] = 32'd2; ed[3] = 32'd2;
        send_ar(32'h103, 4'd3, 3'd0, 2'd1, 4'hA);
        get_r(4'd3, 4'hA, 1'b0);

        // address bits above the RAM alias
        ed[0] = 32'd1;
        send_ar(32'h4100, 4'd0, 3'd2, 2'd1, 4'h1);
        get_r(4'd0, 4'h1, 1'b0);

        // FIXED burst writes the same word twice
        wd[0] = 32'd5; wd[1] = 32'd6; ws[0] = 4'hF; ws[1] = 4'hF;
        send_aw(32'h300, 4'd1, 3'd2, 2'd0, 4'h9);
        send_w(4'd1, 1);
        get_b(2'b00, 4'h9);
        ed[0] = 32'd6; ed[1] = 32'd6;
        send_ar(32'h300, 4'd1, 3'd2, 2'd0, 4'h9);
        get_r(4'd1, 4'h9, 1'b0);

        // early wlast: both beats still taken, SLVERR
        wd[0] = 32'h11; wd[1] = 32'h22; ws[0] = 4'hF; ws[1] = 4'hF;
        send_aw(32'h200, 4'd1, 3'd2, 2'd1, 4'h2);
        send_w(4'd1, 0);
        get_b(2'b10, 4'h2);
        ed[0] = 32'h11; ed[1] = 32'h22;
        send_ar(32'h200, 4'd1, 3'd2, 2'd1, 4'h2);
        get_r(4'd1, 4'h2, 1'b0);

        // arbitration after reset: read first, then the pending write, then read again
        do_reset();
        awaddr = 32'h10; awlen = 4'd0; awsize = 3'd2; awburst = 2'd1; awid = 4'h1; awvalid = 1'b1;
        araddr = 32'h10; arlen = 4'd0; arsize = 3'd2; arburst = 2'd1; arid = 4'h2; arvalid = 1'b1;
        #1;
        check("arb1_arready", 32'(arready), 32'd1);
        check("arb1_awready", 32'(awready), 32'd0);
        @(negedge clk);
        ed[0] = 32'hDEADAAEF;
        get_r(4'd0, 4'h2, 1'b0);
        #1;
        check("arb2_awready", 32'(awready), 32'd1);
        check("arb2_arready", 32'(arready), 32'd0);
        @(negedge clk);
        awvalid = 1'b0;
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        send_w(4'd0, 0);
        get_b(2'b00, 4'h1);
        ed[0] = 32'hCAFEF00D;
        send_ar(32'h10, 4'd0, 3'd2, 2'd1, 4'h2);
        get_r(4'd0, 4'h2, 1'b0);

        // reset in the middle of a read burst
        send_ar(32'h100, 4'd3, 3'd2, 2'd1, 4'h7);
        rready = 1'b1;
        seen = 0; t = 0;
        while (seen < 3 && t < 40) begin
            @(negedge clk);
            if (rvalid) seen++;
            t++;
        end
        check("midrst_beats_seen", 32'(seen), 32'd3);
        check("midrst_beat2_data", rdata, 32'd3);
        resetn = 1'b0;
        #1;
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_rlast", 32'(rlast), 32'd0);
        rready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("postrst_rvalid", 32'(rvalid), 32'd0);
        ed[0] = 32'd2;
        send_ar(32'h104, 4'd0, 3'd2, 2'd1, 4'h8);
        get_r(4'd0, 4'h8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
